// File: rtl/sync_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : sync_pkg                                                    |
// | Description : Shared Q-format constants and helpers for the symbol-sync   |
// |               datapath (timing controller, Farrow interpolator, ...).    |
// |               Q format is sign.integer.fraction = 1.1.14 by default, so   |
// |               1.0 is 'h4000 and the fraction width follows from it.       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package sync_pkg;

   // 1.0 in the Q format; the fractional interval mu lives in [0, Q_ONE).
   localparam int Q_ONE   = 'h4000;
   localparam int Q_SYM   = 1;
   localparam int Q_INT   = 1;
   localparam int Q_DEC   = $clog2(Q_ONE);
   localparam int Q_GUARD = 2;

   // Half an output LSB after dropping frac_width fraction bits: adding this
   // before the arithmetic shift gives round-half-up.
   function automatic int round_const(input int frac_width);
      return 1 << (frac_width - 1);
   endfunction

endpackage : sync_pkg
`default_nettype wire

// File: rtl/farrow_interp_mac.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : farrow_mac                                                  |
// | Description : Registered multiply-accumulate y = round(a*mu >> FRAC) + b.|
// |               The result is either clamped to Y_WIDTH (SATURATE=1) or    |
// |               wrapped (SATURATE=0); clip_o flags a result that did not   |
// |               fit. Result/clip registers load only with vld_i so the     |
// |               output holds between valid pulses.                         |
// | Ports       : clk, rst        - clock, async active-high reset           |
// |               vld_i / vld_o   - input qualifier / registered qualifier   |
// |               a_i, mu_i, b_i  - signed multiplicand, interval, addend    |
// |               y_o, clip_o     - registered result and out-of-range flag  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module farrow_mac
   import sync_pkg::*;
#(
   parameter int A_WIDTH    = 18,
   parameter int MU_WIDTH   = 16,
   parameter int B_WIDTH    = 18,
   parameter int Y_WIDTH    = 18,
   parameter int FRAC_WIDTH = 14,
   parameter int SATURATE   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       vld_i,
   input  logic signed [A_WIDTH-1:0]  a_i,
   input  logic signed [MU_WIDTH-1:0] mu_i,
   input  logic signed [B_WIDTH-1:0]  b_i,
   output logic signed [Y_WIDTH-1:0]  y_o,
   output logic                       vld_o,
   output logic                       clip_o
);

   // One spare bit over the full product so the rounding add cannot wrap.
   localparam int P_WIDTH = A_WIDTH + MU_WIDTH + 1;
   localparam logic signed [P_WIDTH-1:0] RND   = P_WIDTH'(round_const(FRAC_WIDTH));
   localparam logic signed [P_WIDTH-1:0] Y_MAX = (P_WIDTH'(1) <<< (Y_WIDTH - 1)) - P_WIDTH'(1);
   localparam logic signed [P_WIDTH-1:0] Y_MIN = -(P_WIDTH'(1) <<< (Y_WIDTH - 1));

   logic signed [P_WIDTH-1:0] prod;
   logic signed [P_WIDTH-1:0] rnd;
   logic signed [P_WIDTH-1:0] sum;
   logic signed [Y_WIDTH-1:0] y_d;
   logic                      clip_d;
   logic signed [Y_WIDTH-1:0] y_q;
   logic                      vld_q;
   logic                      clip_q;

   assign prod   = P_WIDTH'(a_i) * P_WIDTH'(mu_i);
   assign rnd    = (prod + RND) >>> FRAC_WIDTH;
   assign sum    = rnd + P_WIDTH'(b_i);
   assign clip_d = (sum > Y_MAX) || (sum < Y_MIN);

   generate
      if (SATURATE != 0) begin : g_sat
         always_comb begin
            y_d = Y_WIDTH'(sum);
            if (sum > Y_MAX) begin
               y_d = Y_WIDTH'(Y_MAX);
            end else if (sum < Y_MIN) begin
               y_d = Y_WIDTH'(Y_MIN);
            end
         end
      end else begin : g_wrap
         assign y_d = Y_WIDTH'(sum);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q    <= '0;
         vld_q  <= 1'b0;
         clip_q <= 1'b0;
      end else begin
         vld_q <= vld_i;
         if (vld_i) begin
            y_q    <= y_d;
            clip_q <= clip_d;
         end
      end
   end

   assign y_o    = y_q;
   assign vld_o  = vld_q;
   assign clip_o = clip_q;

endmodule : farrow_mac
`default_nettype wire

// File: rtl/farrow_interp.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : farrow_interp                                               |
// | Description : Piecewise-parabolic Farrow interpolator (alpha = 0.5).     |
// |               Keeps a 4-sample delay line of the matched-filter output   |
// |               and, for each accepted timing strobe, produces one         |
// |               interpolated sample between x(m)=d2 (mu=0) and x(m+1)=d1.  |
// |               Three register stages, one strobe per cycle, no stall.     |
// | Ports       : clk, rst     - clock, async active-high reset              |
// |               data_in      - signed sample-rate input                    |
// |               data_valid   - data_in qualifier                           |
// |               mk, uk       - strobe and fractional interval mu          |
// |               interp_out   - interpolated sample (held between pulses)  |
// |               interp_valid - single-cycle qualifier for interp_out      |
// |               sat_flag     - sticky, set by any clipped result          |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module farrow_interp
   import sync_pkg::*;
#(
   parameter int SYM_WIDTH    = Q_SYM,
   parameter int INT_WIDTH    = Q_INT,
   parameter int DEC_WIDTH    = Q_DEC,
   parameter int GUARD_WIDTH  = Q_GUARD,
   localparam int DATA_WIDTH  = SYM_WIDTH + INT_WIDTH + DEC_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   input  logic                         data_valid,
   input  logic                         mk,
   input  logic signed [DATA_WIDTH-1:0] uk,
   output logic signed [DATA_WIDTH-1:0] interp_out,
   output logic                         interp_valid,
   output logic                         sat_flag
);

   localparam int         V_WIDTH   = DATA_WIDTH + GUARD_WIDTH;
   localparam logic [2:0] FILL_FULL = 3'd4;

   // Delay line: d0 = x(m+2) newest ... d3 = x(m-1) oldest.
   logic signed [DATA_WIDTH-1:0] d0_q, d1_q, d2_q, d3_q;
   logic [2:0]                   fill_q, fill_d;
   logic                         accept;

   // Stage 1: Farrow coefficients
   logic signed [V_WIDTH-1:0]    s2, s1, v2_d, v1_d;
   logic signed [V_WIDTH-1:0]    v2_q, v1_q;
   logic signed [DATA_WIDTH-1:0] v0_q, mu1_q;
   logic                         vld1_q;

   // Stage 2 -> 3 side-band (v0 and mu travel alongside t)
   logic signed [DATA_WIDTH-1:0] v0_s2_q, mu2_q;
   logic signed [V_WIDTH-1:0]    t;
   logic                         vld2, clip2;
   logic                         vld3, clip3;
   logic                         sat_hit, sat_q;

   assign accept = data_valid && mk && (fill_q == FILL_FULL);
   assign fill_d = (data_valid && (fill_q != FILL_FULL)) ? fill_q + 3'd1 : fill_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d0_q   <= '0;
         d1_q   <= '0;
         d2_q   <= '0;
         d3_q   <= '0;
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
         if (data_valid) begin
            d3_q <= d2_q;
            d2_q <= d1_q;
            d1_q <= d0_q;
            d0_q <= data_in;
         end
      end
   end

   // The 0.5 factors are exact arithmetic shifts (floor); guard bits keep the
   // four-term sums from wrapping for any full-scale input.
   assign s2   = V_WIDTH'(d0_q) - V_WIDTH'(d1_q) - V_WIDTH'(d2_q) + V_WIDTH'(d3_q);
   assign s1   = V_WIDTH'(d1_q) - V_WIDTH'(d0_q) - V_WIDTH'(d2_q) - V_WIDTH'(d3_q);
   assign v2_d = s2 >>> 1;
   assign v1_d = V_WIDTH'(d1_q) + (s1 >>> 1);

   // Captured from the pre-shift delay line, so the sample arriving with the
   // strobe is not part of this interpolation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q    <= '0;
         v1_q    <= '0;
         v0_q    <= '0;
         mu1_q   <= '0;
         vld1_q  <= 1'b0;
         v0_s2_q <= '0;
         mu2_q   <= '0;
      end else begin
         vld1_q <= accept;
         if (accept) begin
            v2_q  <= v2_d;
            v1_q  <= v1_d;
            v0_q  <= d2_q;
            mu1_q <= uk;
         end
         if (vld1_q) begin
            v0_s2_q <= v0_q;
            mu2_q   <= mu1_q;
         end
      end
   end

   // Stage 2: t = round(v2*mu) + v1, kept at the guarded width.
   farrow_mac #(
      .A_WIDTH    (V_WIDTH),
      .MU_WIDTH   (DATA_WIDTH),
      .B_WIDTH    (V_WIDTH),
      .Y_WIDTH    (V_WIDTH),
      .FRAC_WIDTH (DEC_WIDTH),
      .SATURATE   (0)
   ) u_mac_s2 (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (vld1_q),
      .a_i    (v2_q),
      .mu_i   (mu1_q),
      .b_i    (v1_q),
      .y_o    (t),
      .vld_o  (vld2),
      .clip_o (clip2)
   );

   // Stage 3: y = sat(round(t*mu) + v0); its register is the output register.
   farrow_mac #(
      .A_WIDTH    (V_WIDTH),
      .MU_WIDTH   (DATA_WIDTH),
      .B_WIDTH    (DATA_WIDTH),
      .Y_WIDTH    (DATA_WIDTH),
      .FRAC_WIDTH (DEC_WIDTH),
      .SATURATE   (1)
   ) u_mac_s3 (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (vld2),
      .a_i    (t),
      .mu_i   (mu2_q),
      .b_i    (v0_s2_q),
      .y_o    (interp_out),
      .vld_o  (vld3),
      .clip_o (clip3)
   );

   // clip flags are only meaningful in the cycle their stage is valid.
   assign sat_hit = (vld2 && clip2) || (vld3 && clip3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= sat_q || sat_hit;
      end
   end

   // OR-in the live hit so the flag rises together with the clipped sample.
   assign sat_flag     = sat_q || sat_hit;
   assign interp_valid = vld3;

endmodule : farrow_interp
`default_nettype wire

// File: tb/tb_farrow_interp.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_farrow_interp                                            |
// | Description : Self-checking bench for farrow_interp. A reference model   |
// |               keeps the sample history in a queue and evaluates the      |
// |               parabolic Farrow polynomial with integer arithmetic.       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_farrow_interp;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] data_in;
   logic               data_valid;
   logic               mk;
   logic signed [15:0] uk;
   logic signed [15:0] interp_out;
   logic               interp_valid;
   logic               sat_flag;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int hist[$];          // hist[0] = newest sample
   bit pv[3];            // strobe result age 0/1/2 cycles
   int py[3];
   bit pc[3];
   bit m_vld;
   int m_out;
   bit m_sat;

   farrow_interp dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .mk           (mk),
      .uk           (uk),
      .interp_out   (interp_out),
      .interp_valid (interp_valid),
      .sat_flag     (sat_flag)
   );

   always #5 clk = ~clk;

   function automatic longint round_q14(input longint x);
      return (x + 8192) >>> 14;   // floor(x/2^14 + 0.5)
   endfunction

   // y(mu) = (v2*mu + v1)*mu + v0 with xm1=x(m-1), xm=x(m), xp1=x(m+1), xp2=x(m+2)
   function automatic longint farrow_ref(input int xm1, input int xm, input int xp1,
                                         input int xp2, input int mu);
      int     v2, v1;
      longint t;
      v2 = (xp2 - xp1 - xm + xm1) >>> 1;
      v1 = xp1 + ((xp1 - xp2 - xm - xm1) >>> 1);
      t  = round_q14(longint'(v2) * mu) + v1;
      return round_q14(t * mu) + xm;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 3; i++) begin
         pv[i] = 1'b0; py[i] = 0; pc[i] = 1'b0;
      end
      m_vld = 1'b0; m_out = 0; m_sat = 1'b0;
   endtask

   // Drive one cycle (called at a negedge), advance the model at the posedge,
   // return at the next negedge where outputs are sampled.
   task automatic cyc(input bit dv, input int din, input bit m, input int u);
      logic signed [15:0] s16;
      longint raw;
      s16        = 16'(din);
      data_valid = dv;
      data_in    = s16;
      mk         = m;
      uk         = 16'(u);
      @(posedge clk);
      for (int i = 2; i > 0; i--) begin
         pv[i] = pv[i-1]; py[i] = py[i-1]; pc[i] = pc[i-1];
      end
      pv[0] = dv && m && (hist.size() == 4);
      pc[0] = 1'b0;
      if (pv[0]) begin
         raw = farrow_ref(hist[3], hist[2], hist[1], hist[0], u);
         if (raw > 32767)       begin py[0] = 32767;  pc[0] = 1'b1; end
         else if (raw < -32768) begin py[0] = -32768; pc[0] = 1'b1; end
         else                   py[0] = int'(raw);
      end
      m_vld = pv[2];
      if (pv[2]) begin
         m_out = py[2];
         if (pc[2]) m_sat = 1'b1;
      end
      if (dv) begin
         hist.push_front(int'(s16));
         if (hist.size() > 4) void'(hist.pop_back());
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int rnd16();
      return int'($urandom_range(0, 65535));
   endfunction

   function automatic int rnd_mu();
      return int'($urandom_range(0, 16383));
   endfunction

   task automatic test_reset();
      rst = 1'b1; data_valid = 1'b0; mk = 1'b0; data_in = '0; uk = '0;
      model_reset();
      @(negedge clk);
      n_cmp++; if (interp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", interp_valid); end
      n_cmp++; if (interp_out !== 16'sd0) begin n_err++; $display("FAIL reset_out: got %0d want 0", interp_out); end
      n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
      rst = 1'b0;
   endtask

   task automatic test_fill_gating();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i < 5) cyc(1'b1, rnd16(), 1'b1, rnd_mu());
         else       cyc(1'b0, 0, 1'b0, 0);
         n_cmp++; if (interp_valid !== m_vld) begin n_err++; $display("FAIL fill_valid[%0d]: got %b want %b", i, interp_valid, m_vld); end
         n_cmp++; if (interp_out !== 16'(m_out)) begin n_err++; $display("FAIL fill_out[%0d]: got %0d want %0d", i, interp_out, m_out); end
         // only the 5th strobe (i==4) is accepted; it shows up after i==6
         n_cmp++; if (interp_valid !== (i == 6)) begin n_err++; $display("FAIL fill_timing[%0d]: got %b want %b", i, interp_valid, (i == 6)); end
      end
   endtask

   task automatic test_constant();
      int mus[3] = '{'h0000, 'h1555, 'h3FFF};
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 'h1000, 1'b0, 0);
      foreach (mus[k]) begin
         cyc(1'b1, 'h1000, 1'b1, mus[k]);
         cyc(1'b0, 0, 1'b0, 0);
         cyc(1'b0, 0, 1'b0, 0);
         n_cmp++; if (interp_valid !== 1'b1) begin n_err++; $display("FAIL const_valid[%0d]: got %b want 1", k, interp_valid); end
         n_cmp++; if (interp_out !== 16'sh1000) begin n_err++; $display("FAIL const_out[%0d]: got 0x%h want 0x1000", k, interp_out); end
         n_cmp++; if (interp_out !== 16'(m_out)) begin n_err++; $display("FAIL const_model[%0d]: got %0d want %0d", k, interp_out, m_out); end
      end
   endtask

   task automatic test_ramp();
      int mus[2]  = '{'h2000, 'h0000};
      int want[2] = '{'h0600, 'h0400};
      foreach (mus[k]) begin
         do_reset();
         for (int i = 0; i < 4; i++) cyc(1'b1, i * 'h400, 1'b0, 0);
         cyc(1'b1, rnd16(), 1'b1, mus[k]);
         cyc(1'b0, 0, 1'b0, 0);
         cyc(1'b0, 0, 1'b0, 0);
         n_cmp++; if (interp_valid !== 1'b1) begin n_err++; $display("FAIL ramp_valid[%0d]: got %b want 1", k, interp_valid); end
         n_cmp++; if (interp_out !== 16'(want[k])) begin n_err++; $display("FAIL ramp_out[%0d]: got 0x%h want 0x%h", k, interp_out, 16'(want[k])); end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      cyc(1'b1, 'h7FFF, 1'b0, 0);
      cyc(1'b1, 'h7FFF, 1'b0, 0);
      cyc(1'b1, 'h7FFF, 1'b0, 0);
      cyc(1'b1, 'h8000, 1'b0, 0);
      cyc(1'b1, 'h0100, 1'b1, 'h3000);
      n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_early: got %b want 0", sat_flag); end
      cyc(1'b0, 0, 1'b0, 0);
      cyc(1'b0, 0, 1'b0, 0);
      n_cmp++; if (interp_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %b want 1", interp_valid); end
      n_cmp++; if (interp_out !== 16'sh7FFF) begin n_err++; $display("FAIL sat_out: got 0x%h want 0x7fff", interp_out); end
      n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", sat_flag); end
      // clean traffic afterwards: flag must stay set
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, int'($urandom_range(0, 'h0400)), (i >= 4), rnd_mu());
         n_cmp++; if (interp_out !== 16'(m_out)) begin n_err++; $display("FAIL sat_clean_out[%0d]: got %0d want %0d", i, interp_out, m_out); end
         n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_sticky[%0d]: got %b want 1", i, sat_flag); end
      end
   endtask

   task automatic test_back_to_back();
      int cnt = 0, first = -1, last = -1;
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, rnd16(), 1'b0, 0);
      for (int i = 0; i < 10; i++) begin
         if (i < 4) cyc(1'b1, rnd16(), 1'b1, rnd_mu());
         else       cyc(1'b0, rnd16(), 1'b1, rnd_mu());   // mk without data_valid
         n_cmp++; if (interp_valid !== m_vld) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, interp_valid, m_vld); end
         n_cmp++; if (interp_out !== 16'(m_out)) begin n_err++; $display("FAIL b2b_out[%0d]: got %0d want %0d", i, interp_out, m_out); end
         n_cmp++; if (sat_flag !== m_sat) begin n_err++; $display("FAIL b2b_sat[%0d]: got %b want %b", i, sat_flag, m_sat); end
         if (interp_valid === 1'b1) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      n_cmp++; if (cnt != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", cnt); end
      n_cmp++; if (first != 2 || last != 5) begin n_err++; $display("FAIL b2b_window: got %0d..%0d want 2..5", first, last); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) < 7), rnd16(), ($urandom_range(0, 1) == 1), rnd_mu());
         n_cmp++; if (interp_valid !== m_vld) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", i, interp_valid, m_vld); end
         n_cmp++; if (interp_out !== 16'(m_out)) begin n_err++; $display("FAIL rand_out[%0d]: got %0d want %0d", i, interp_out, m_out); end
         n_cmp++; if (sat_flag !== m_sat) begin n_err++; $display("FAIL rand_sat[%0d]: got %b want %b", i, sat_flag, m_sat); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 'h7FFF, 1'b0, 0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 'h8000, 1'b1, 'h3000);
      n_cmp++; if (interp_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", interp_valid); end
      rst = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (interp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", interp_valid); end
      n_cmp++; if (interp_out !== 16'sd0) begin n_err++; $display("FAIL mid_rst_out: got %0d want 0", interp_out); end
      n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL mid_rst_sat: got %b want 0", sat_flag); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i < 3)      cyc(1'b0, 0, 1'b0, 0);
         else if (i < 8) cyc(1'b1, rnd16(), 1'b1, rnd_mu());   // 5th one (i==7) accepted
         else            cyc(1'b0, 0, 1'b0, 0);
         n_cmp++; if (interp_valid !== (i == 9)) begin n_err++; $display("FAIL mid_refill[%0d]: got %b want %b", i, interp_valid, (i == 9)); end
         n_cmp++; if (interp_out !== 16'(m_out)) begin n_err++; $display("FAIL mid_out[%0d]: got %0d want %0d", i, interp_out, m_out); end
      end
   endtask

   initial begin
      test_reset();
      test_fill_gating();
      test_constant();
      test_ramp();
      test_saturation();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_farrow_interp
`default_nettype wire
